// File: rtl/cdb_writeback_arbiter_if.sv
// CDB writeback bus between functional-unit requesters and the arbiter.
//   req_v_i     : per-requester writeback valid (requester -> arbiter)
//   req_data_i  : per-requester payload (dest tag + data)
//   req_ready_o : per-requester grant, one-hot or zero (arbiter -> requester)
//   cdb_v_o     : registered CDB broadcast valid
//   cdb_data_o  : registered CDB payload
//   cdb_src_o   : index of the requester that produced the broadcast
// master = requester side, slave = arbiter side.
interface cdb_writeback_arbiter_if #(
  parameter int NUM_REQ_P       = 4,
  parameter int PAYLOAD_WIDTH_P = 16
);
  localparam int SRC_W = $clog2(NUM_REQ_P);

  logic [NUM_REQ_P-1:0]                      req_v_i;
  logic [NUM_REQ_P-1:0][PAYLOAD_WIDTH_P-1:0] req_data_i;
  logic [NUM_REQ_P-1:0]                      req_ready_o;
  logic                                      cdb_v_o;
  logic [PAYLOAD_WIDTH_P-1:0]                cdb_data_o;
  logic [SRC_W-1:0]                          cdb_src_o;

  modport master (
    output req_v_i, req_data_i,
    input  req_ready_o, cdb_v_o, cdb_data_o, cdb_src_o
  );

  modport slave (
    input  req_v_i, req_data_i,
    output req_ready_o, cdb_v_o, cdb_data_o, cdb_src_o
  );
endinterface

// File: rtl/cdb_writeback_arbiter.sv
// Common-data-bus writeback arbiter with age-based urgency.
// Grants one requester per cycle (lowest-index urgent requester first,
// otherwise lowest-index valid requester) and registers the winner's
// payload onto the CDB one cycle later.
//   clk_i     : sole clock, rising edge
//   reset_n_i : asynchronous active-low reset
//   flush_i   : mispredict flush; suppresses grants, kills next broadcast,
//               clears all wait counters
//   bus       : slave side of cdb_writeback_arbiter_if (requests, grants,
//               CDB broadcast)
module cdb_writeback_arbiter #(
  parameter int NUM_REQ_P       = 4,
  parameter int PAYLOAD_WIDTH_P = 16,
  parameter int AGE_LIMIT_P     = 3
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic                     flush_i,
  cdb_writeback_arbiter_if.slave   bus
);

  localparam int unsigned SRC_W = $clog2(NUM_REQ_P);
  localparam int unsigned CNT_W = $clog2(AGE_LIMIT_P + 1);
  localparam logic [CNT_W-1:0] AGE_MAX = CNT_W'(AGE_LIMIT_P);

  logic [NUM_REQ_P-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [NUM_REQ_P-1:0]            urgent;
  logic [NUM_REQ_P-1:0]            grant;
  logic                            grant_v;
  logic [SRC_W-1:0]                grant_idx;
  logic [SRC_W-1:0]                urg_idx, any_idx;
  logic                            urg_found, any_found;

  logic                       cdb_v_q, cdb_v_d;
  logic [PAYLOAD_WIDTH_P-1:0] cdb_data_q, cdb_data_d;
  logic [SRC_W-1:0]           cdb_src_q, cdb_src_d;

  // Grant selection: two priority scans in one pass, urgent scan wins.
  // reset_n_i gates the grant so req_ready_o drops asynchronously in reset.
  always_comb begin
    urg_found = 1'b0;
    any_found = 1'b0;
    urg_idx   = '0;
    any_idx   = '0;
    urgent    = '0;
    for (int unsigned i = 0; i < NUM_REQ_P; i++) begin
      urgent[i] = bus.req_v_i[i] && (cnt_q[i] == AGE_MAX);
      if (!urg_found && urgent[i]) begin
        urg_found = 1'b1;
        urg_idx   = SRC_W'(i);
      end
      if (!any_found && bus.req_v_i[i]) begin
        any_found = 1'b1;
        any_idx   = SRC_W'(i);
      end
    end
    grant_v   = any_found && !flush_i && reset_n_i;
    grant_idx = urg_found ? urg_idx : any_idx;
    grant     = '0;
    for (int unsigned i = 0; i < NUM_REQ_P; i++) begin
      grant[i] = grant_v && (grant_idx == SRC_W'(i));
    end
  end

  assign bus.req_ready_o = grant;

  // Wait counters saturate so losing urgent requesters stay urgent.
  always_comb begin
    cnt_d = cnt_q;
    for (int unsigned i = 0; i < NUM_REQ_P; i++) begin
      if (flush_i || !bus.req_v_i[i] || grant[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] != AGE_MAX) begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  always_comb begin
    cdb_v_d    = grant_v;
    cdb_data_d = cdb_data_q;
    cdb_src_d  = cdb_src_q;
    if (grant_v) begin
      cdb_data_d = bus.req_data_i[grant_idx];
      cdb_src_d  = grant_idx;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      cnt_q      <= '0;
      cdb_v_q    <= 1'b0;
      cdb_data_q <= '0;
      cdb_src_q  <= '0;
    end else begin
      cnt_q      <= cnt_d;
      cdb_v_q    <= cdb_v_d;
      cdb_data_q <= cdb_data_d;
      cdb_src_q  <= cdb_src_d;
    end
  end

  assign bus.cdb_v_o    = cdb_v_q;
  assign bus.cdb_data_o = cdb_data_q;
  assign bus.cdb_src_o  = cdb_src_q;

endmodule
